// File: rtl/obj_centroid.sv
// obj_centroid: accumulates lit-pixel coordinates per frame and computes the object centroid
// with a serial restoring divider started at each vertical-sync rising edge.
module obj_centroid #(
  parameter int MIN_PIXELS = 16
) (
  input  logic        PClk,
  input  logic        Rst_n,
  input  logic        Binary_in,
  input  logic        VtcDe,
  input  logic        VtcVs,
  input  logic [11:0] VtcHCnt,
  input  logic [11:0] VtcVCnt,
  output logic [11:0] center_h,
  output logic [11:0] center_v,
  output logic        obj_valid,
  output logic        center_update
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CHECK  = 3'd1;
  localparam logic [2:0] DIV_H  = 3'd2;
  localparam logic [2:0] DIV_V  = 3'd3;
  localparam logic [2:0] UPDATE = 3'd4;
  localparam logic [23:0] MIN_CNT = 24'(MIN_PIXELS);
  logic [2:0]  state;
  logic        vs_q, armed, ok;
  logic [35:0] sum_h, sum_v, snap_h, snap_v, dq;
  logic [23:0] cnt, snap_cnt, rem, nrem;
  logic [5:0]  bit_cnt;
  logic [11:0] qh;
  logic        frame_end, pix, ge;
  logic [24:0] sh;
  // armed blocks a VtcVs already high at reset release from looking like a rising edge
  always_comb begin
    frame_end = VtcVs & ~vs_q & armed;
    pix       = VtcDe & Binary_in;
    sh        = {rem, dq[35]};
    ge        = sh >= {1'b0, snap_cnt};
    nrem      = ge ? 24'(sh - {1'b0, snap_cnt}) : sh[23:0];
  end
  always_ff @(posedge PClk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      vs_q          <= 1'b0;
      armed         <= 1'b0;
      ok            <= 1'b0;
      sum_h         <= '0;
      sum_v         <= '0;
      cnt           <= '0;
      snap_h        <= '0;
      snap_v        <= '0;
      snap_cnt      <= '0;
      dq            <= '0;
      rem           <= '0;
      bit_cnt       <= '0;
      qh            <= 12'hFFF;
      center_h      <= 12'hFFF;
      center_v      <= 12'hFFF;
      obj_valid     <= 1'b0;
      center_update <= 1'b0;
    end else begin
      vs_q          <= VtcVs;
      armed         <= armed | ~VtcVs;
      sum_h         <= (frame_end ? 36'd0 : sum_h) + (pix ? 36'(VtcHCnt) : 36'd0);
      sum_v         <= (frame_end ? 36'd0 : sum_v) + (pix ? 36'(VtcVCnt) : 36'd0);
      cnt           <= (frame_end ? 24'd0 : cnt) + 24'(pix);
      center_update <= state == UPDATE;
      case (state)
        IDLE: if (frame_end) begin
          snap_h   <= sum_h;
          snap_v   <= sum_v;
          snap_cnt <= cnt;
          state    <= CHECK;
        end
        CHECK: begin
          ok      <= snap_cnt >= MIN_CNT;
          dq      <= snap_cnt >= MIN_CNT ? snap_h : 36'hFFF;
          qh      <= 12'hFFF;
          rem     <= '0;
          bit_cnt <= '0;
          state   <= snap_cnt >= MIN_CNT ? DIV_H : UPDATE;
        end
        DIV_H, DIV_V: begin
          rem     <= nrem;
          dq      <= {dq[34:0], ge};
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == 6'd35) begin
            bit_cnt <= '0;
            rem     <= '0;
            if (state == DIV_H) begin
              qh    <= {dq[10:0], ge};
              dq    <= snap_v;
              state <= DIV_V;
            end else begin
              state <= UPDATE;
            end
          end
        end
        UPDATE: begin
          center_h  <= qh;
          center_v  <= dq[11:0];
          obj_valid <= ok;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_obj_centroid.sv
// tb_obj_centroid: directed frames with a scoreboard queue checked by a monitor on every center_update.
module tb_obj_centroid;
  logic        PClk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Binary_in = 1'b0;
  logic        VtcDe = 1'b0;
  logic        VtcVs = 1'b0;
  logic [11:0] VtcHCnt = '0;
  logic [11:0] VtcVCnt = '0;
  logic [11:0] center_h, center_v;
  logic        obj_valid, center_update;
  int          tests = 0;
  int          fails = 0;
  int          edge_n = 0;
  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic        ok;
    int          e;
  } exp_t;
  exp_t sb[$];

  obj_centroid #(.MIN_PIXELS(2)) dut (
    .PClk(PClk), .Rst_n(Rst_n), .Binary_in(Binary_in), .VtcDe(VtcDe), .VtcVs(VtcVs),
    .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt), .center_h(center_h), .center_v(center_v),
    .obj_valid(obj_valid), .center_update(center_update)
  );

  always #5 PClk = ~PClk;
  always @(posedge PClk) edge_n <= edge_n + 1;

  always @(negedge PClk) begin
    if (center_update) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_update edge=%0d h=%0d v=%0d valid=%0b", edge_n, center_h, center_v, obj_valid);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (center_h !== x.h || center_v !== x.v || obj_valid !== x.ok || edge_n != x.e) begin
          fails++;
          $display("FAIL update got h=%0d v=%0d valid=%0b edge=%0d expected h=%0d v=%0d valid=%0b edge=%0d",
                   center_h, center_v, obj_valid, edge_n, x.h, x.v, x.ok, x.e);
        end
      end
    end
  end

  task automatic step(input logic de, input int h, input int v, input logic vs);
    @(negedge PClk);
    VtcDe = de;
    Binary_in = de;
    VtcHCnt = h[11:0];
    VtcVCnt = v[11:0];
    VtcVs = vs;
  endtask

  task automatic expect_upd(input int lat, input int h, input int v, input logic ok, output int e0);
    exp_t x;
    e0 = edge_n + 1;
    x.h = h[11:0];
    x.v = v[11:0];
    x.ok = ok;
    x.e = e0 + lat;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic to_edge(input int e);
    while (edge_n + 1 < e) step(0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    VtcVs = 1'b1;
    repeat (3) @(negedge PClk);
    chk("reset_center_h", center_h, 12'hFFF);
    chk("reset_center_v", center_v, 12'hFFF);
    chk("reset_valid_update", {10'd0, obj_valid, center_update}, 12'd0);
    Rst_n = 1'b1;
    repeat (5) step(0, 0, 0, 1);
    idle(5);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) step(1, 100 + j, 200 + i, 0);
    step(1, 10, 50, 1);
    expect_upd(74, 101, 201, 1, e0);
    step(1, 11, 51, 0);
    idle(80);
    step(0, 0, 0, 1);
    expect_upd(74, 10, 50, 1, e0);
    step(1, 5, 5, 0);
    idle(80);
    step(0, 0, 0, 1);
    expect_upd(2, 12'hFFF, 12'hFFF, 0, e0);
    idle(10);
    step(0, 0, 0, 1);
    expect_upd(2, 12'hFFF, 12'hFFF, 0, e0);
    idle(10);
    for (int i = 0; i < 640; i++) step(1, i, 0, 0);
    for (int i = 0; i < 640; i++) step(1, i, 478, 0);
    step(0, 0, 0, 1);
    expect_upd(74, 319, 239, 1, e0);
    idle(80);
    repeat (20) step(1, 4095, 4095, 0);
    step(0, 0, 0, 1);
    expect_upd(74, 4095, 4095, 1, e0);
    idle(80);
    step(1, 30, 40, 0);
    step(1, 32, 42, 0);
    step(0, 0, 0, 1);
    expect_upd(74, 31, 41, 1, e0);
    repeat (3) step(1, 1, 1, 0);
    to_edge(e0 + 20);
    step(0, 0, 0, 1);
    step(1, 200, 300, 0);
    step(1, 202, 302, 0);
    to_edge(e0 + 80);
    step(0, 0, 0, 1);
    expect_upd(74, 201, 301, 1, e0);
    idle(80);
    step(1, 50, 60, 0);
    step(1, 52, 62, 0);
    step(0, 0, 0, 1);
    e0 = edge_n + 1;
    to_edge(e0 + 40);
    @(negedge PClk);
    VtcVs = 1'b0;
    VtcDe = 1'b0;
    Binary_in = 1'b0;
    Rst_n = 1'b0;
    #1;
    chk("midreset_center_h", center_h, 12'hFFF);
    chk("midreset_center_v", center_v, 12'hFFF);
    chk("midreset_valid", {11'd0, obj_valid}, 12'd0);
    idle(2);
    Rst_n = 1'b1;
    idle(80);
    step(1, 7, 8, 0);
    step(1, 9, 10, 0);
    step(0, 0, 0, 1);
    expect_upd(74, 8, 9, 1, e0);
    idle(80);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL pending_updates got=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/obj_centroid.md
OBJ_CENTROID -- requirements
Module: obj_centroid

Interface
REQ-001 The block SHALL have one clock, PClk, and an asynchronous, active-low reset, Rst_n.
REQ-002 Parameter MIN_PIXELS, default 16: minimum lit pixels per frame for a valid object.
REQ-003 Port PClk, input, 1 bit: pixel clock; all state is updated on its rising edge.
REQ-004 Port Rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port Binary_in, input, 1 bit: segmented pixel, where 1 means object.
REQ-006 Port VtcDe, input, 1 bit: active-video qualifier.
REQ-007 Port VtcVs, input, 1 bit: vertical sync, active high; its rising edge marks end of frame.
REQ-008 Port VtcHCnt, input, 12 bits: current pixel column.
REQ-009 Port VtcVCnt, input, 12 bits: current pixel row.
REQ-010 Port center_h, output, 12 bits: object centroid column (registered).
REQ-011 Port center_v, output, 12 bits: object centroid row (registered).
REQ-012 Port obj_valid, output, 1 bit: the last completed frame contained a valid object.
REQ-013 Port center_update, output, 1 bit: one-cycle pulse when the outputs are refreshed.

Function
REQ-014 Accumulation: each cycle with VtcDe=1 and Binary_in=1, the block SHALL add VtcHCnt to sum_h (36-bit), VtcVCnt to sum_v (36-bit), and 1 to cnt (24-bit).
- Widths cover 4095x4095 frames of all-lit pixels without overflow.
- No saturation logic is required.
REQ-015 Frame end: VtcVs SHALL be registered; frame_end = VtcVs & ~VtcVs_q.
- The cycle on which frame_end is true is called edge 0.
REQ-016 At edge 0 with the FSM in IDLE:
- snapshot sum_h, sum_v and cnt into snapshot registers;
- clear the accumulators;
- a qualified pixel on that same cycle SHALL be counted into the new frame, not the snapshot.
REQ-017 The FSM SHALL have the states IDLE, CHECK, DIV_H, DIV_V and UPDATE.
REQ-018 IDLE -> CHECK on frame_end.
REQ-019 CHECK (edge 1):
- if snap_cnt < MIN_PIXELS (including 0), go to UPDATE with obj_valid_next=0;
- otherwise go to DIV_H.
REQ-020 DIV_H: restoring divide snap_sum_h / snap_cnt, one quotient bit per cycle, exactly 36 cycles, then go to DIV_V.
REQ-021 DIV_V: same divide on snap_sum_v, exactly 36 cycles, then go to UPDATE.
REQ-022 Quotients SHALL be floor (truncation toward zero); only the low 12 quotient bits are used, since the mean of 12-bit values is at most 4095.
REQ-023 UPDATE (one cycle), in the valid case:
- register center_h and center_v from the quotients and set obj_valid=1;
- pulse center_update=1 for exactly one cycle;
- return to IDLE.
REQ-024 UPDATE, in the invalid case: center_h=center_v=12'hFFF (off-screen, so no crosshair is drawn), obj_valid=0, center_update still pulses.
REQ-025 Total latency:
- valid path: outputs change at edge 74 (1 CHECK + 72 divide + 1 UPDATE);
- invalid path: outputs change at edge 2.
REQ-026 A frame_end while the FSM is not IDLE SHALL still clear the accumulators, SHALL NOT alter the snapshot or the FSM, and that frame's result is dropped.
REQ-027 Outputs SHALL hold their values between UPDATE cycles.
REQ-028 Accumulation SHALL continue independently of divider activity.

Reset
REQ-029 While Rst_n=0:
- center_h = center_v = 12'hFFF;
- obj_valid = 0, center_update = 0;
- FSM in IDLE;
- accumulators, snapshot, divider and VtcVs_q cleared.
REQ-030 Reset asserted mid-division SHALL abort the division with no output update; after release the block waits for the next frame_end.
REQ-031 A VtcVs held high across reset release SHALL NOT generate frame_end (VtcVs_q resets to 0, but the first post-reset frame_end requires a low-to-high transition observed after release).

Verification
REQ-032 3x3 block lit at H 100..102, V 200..202, then VtcVs rising -> at edge 74: center_h=101, center_v=201, obj_valid=1, center_update high for exactly 1 cycle.
REQ-033 Two pixels (10,50) and (11,51), MIN_PIXELS=2 -> center_h=10, center_v=50 (truncation).
REQ-034 Frame with 5 lit pixels, MIN_PIXELS=16 -> at edge 2: center_h=center_v=12'hFFF, obj_valid=0, center_update pulses once; empty frame -> same.
REQ-035 Full 640x480 frame all lit -> center_h=319, center_v=239, no overflow.
REQ-036 Second VtcVs rising edge injected 20 cycles after edge 0 -> first result (edge 74) unchanged, second frame dropped, the frame after it is computed correctly from cleared accumulators.
REQ-037 Rst_n pulsed low at edge 40 of a division -> outputs return to 12'hFFF/0 immediately, no center_update pulse, next frame processed normally.
